cache_flush_walker: RTL

Sequencer that walks every set and way of a set-associative cache on a flush request. It drives the set index and way select into the cache address-select mux, which feeds the tag, dirty and LRU arrays. For each valid dirty line it performs a writeback handshake with the bus-side controller. It sits directly upstream of the cache arrays and replacement logic, and only takes control of the address path while a flush is active.

---
 rtl/cache_flush_walker_if.sv | 28 ++
 rtl/cache_flush_walker.sv | 101 ++++++++++
 2 files changed

// File: rtl/cache_flush_walker_if.sv
// Flush-walker signal bundle between the walker, the cache arrays and the bus-side writeback controller.
interface cache_flush_walker_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 9
);
  logic               FlushCache;
  logic               FlushStage;
  logic [NUMWAYS-1:0] ValidWay;
  logic [NUMWAYS-1:0] DirtyWay;
  logic               WritebackDone;
  logic [SETLEN-1:0]  FlushAdr;
  logic [NUMWAYS-1:0] FlushWay;
  logic               FlushActive;
  logic               WritebackReq;
  logic               ClearDirty;
  logic               ClearValid;
  logic               FlushDone;

  modport master (
    input  FlushCache, FlushStage, ValidWay, DirtyWay, WritebackDone,
    output FlushAdr, FlushWay, FlushActive, WritebackReq, ClearDirty, ClearValid, FlushDone
  );

  modport slave (
    output FlushCache, FlushStage, ValidWay, DirtyWay, WritebackDone,
    input  FlushAdr, FlushWay, FlushActive, WritebackReq, ClearDirty, ClearValid, FlushDone
  );
endinterface

// File: rtl/cache_flush_walker.sv
// Walks every (set, way) of the cache on a flush request and writes back valid dirty lines.
// Define CACHE_FLUSH_INVALIDATE_EN to also invalidate every line as it is walked.
module cache_flush_walker #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_flush_walker_if.master  fw
);
  localparam int WAY_W = (NUMWAYS > 1) ? $clog2(NUMWAYS) : 1;

  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITEBACK, DONE} state_t;

  state_t             state_q, state_d;
  logic [SETLEN-1:0]  set_q, set_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic               active_q, wbreq_q, done_q;
  logic               hit, last_way, last_set, adv;
  logic [NUMWAYS-1:0] way_dec;

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    way_d    = way_q;
    adv      = 1'b0;
    hit      = fw.ValidWay[way_q] & fw.DirtyWay[way_q];
    last_way = (way_q == WAY_W'(NUMWAYS - 1));
    last_set = (set_q == SETLEN'(NUMLINES - 1));
    case (state_q)
      IDLE: begin
        if (fw.FlushCache & ~fw.FlushStage) begin
          set_d   = '0;
          way_d   = '0;
          state_d = READ;
        end
      end
      READ:      state_d = CHECK;
      CHECK: begin
        if (hit) state_d = WRITEBACK;
        else     adv     = 1'b1;
      end
      WRITEBACK: adv     = fw.WritebackDone;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Step to the next way; wrap to the next set, or finish after the last line.
    if (adv) begin
      if (!last_way) begin
        way_d   = way_q + 1'b1;
        state_d = READ;
      end else if (!last_set) begin
        set_d   = set_q + 1'b1;
        way_d   = '0;
        state_d = READ;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      set_q    <= '0;
      way_q    <= '0;
      active_q <= 1'b0;
      wbreq_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      way_q    <= way_d;
      active_q <= (state_d != IDLE);
      wbreq_q  <= (state_d == WRITEBACK);
      done_q   <= (state_d == DONE);
    end
  end

  always_comb begin
    way_dec        = '0;
    way_dec[way_q] = 1'b1;
  end

  assign fw.FlushAdr     = set_q;
  assign fw.FlushWay     = way_dec;
  assign fw.FlushActive  = active_q;
  assign fw.WritebackReq = wbreq_q;
  assign fw.FlushDone    = done_q;
  assign fw.ClearDirty   = wbreq_q & fw.WritebackDone;

`ifdef CACHE_FLUSH_INVALIDATE_EN
  // Clean valid lines are dropped during CHECK; dirty ones once their writeback completes.
  assign fw.ClearValid = (wbreq_q & fw.WritebackDone) |
                         ((state_q == CHECK) & fw.ValidWay[way_q] & ~fw.DirtyWay[way_q]);
`else
  assign fw.ClearValid = 1'b0;
`endif

endmodule
